pll_lock_supervisor: RTL and testbench

- Controller on the reference-clock side of the video PLL: drives the PLL reset, consumes its asynchronous `locked` output, and decides when the generated clock is trustworthy.
- Sequences the PLL reset, waits for lock with a timeout, and requires lock to hold for a qualification window.
- Only then releases the downstream system reset for the video/SRAM domain.
- Handles lock loss, bounded retries and a sticky fault.

---
 rtl/pll_lock_supervisor_if.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 91 +++++++++
 tb/tb_pll_lock_supervisor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL lock input and supervisor status/reset outputs
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic             fault;
  logic [2:0]       state;
  logic [2:0]       retry_count;
  logic [CNT_W-1:0] lock_loss_count;
  modport master (
    input  pll_locked,
    output pll_rst, sys_rst, ready, fault, state, retry_count, lock_loss_count
  );
  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst, ready, fault, state, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies lock and gates the downstream system reset
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4,
  parameter int CNT_W          = 8
) (
  input logic                    refclk,
  input logic                    rst,
  pll_lock_supervisor_if.master  bus
);
  localparam int MX0 = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MX  = MX0 > STABLE_CYCLES ? MX0 : STABLE_CYCLES;
  localparam int CW  = MX > 1 ? $clog2(MX) : 1;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4,
    FAULT     = 3'd5
  } state_t;
  state_t           st, nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       sync;
  logic             lk;
  logic [2:0]       retry, retry_n, r1;
  logic [CNT_W-1:0] loss, loss_n;
  assign lk                  = sync[1];
  assign bus.state           = st;
  assign bus.retry_count     = retry;
  assign bus.lock_loss_count = loss;
  // two-flop synchronizer for the asynchronous PLL lock indicator
  always_ff @(posedge refclk)
    sync <= rst ? 2'b00 : {sync[0], bus.pll_locked};
  // state, shared counter, retry/loss counters and registered outputs decoded from next state
  always_ff @(posedge refclk) begin
    if (rst) begin
      st          <= RESET_PLL;
      cnt         <= '0;
      retry       <= '0;
      loss        <= '0;
      bus.pll_rst <= 1'b1;
      bus.sys_rst <= 1'b1;
      bus.ready   <= 1'b0;
      bus.fault   <= 1'b0;
    end else begin
      st          <= nx;
      cnt         <= nx != st ? '0 : cnt + 1'b1;
      retry       <= retry_n;
      loss        <= loss_n;
      bus.pll_rst <= nx == RESET_PLL || nx == LOST || nx == FAULT;
      bus.sys_rst <= nx != RUN;
      bus.ready   <= nx == RUN;
      bus.fault   <= nx == FAULT;
    end
  end
  // next-state logic; a failed attempt charges the retry budget, a lock loss in RUN does not
  always_comb begin
    nx      = st;
    retry_n = retry;
    loss_n  = loss;
    r1      = retry + 3'd1;
    case (st)
      RESET_PLL: nx = cnt == CW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK:
        if (lk) nx = STABILIZE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_n = r1;
          nx      = r1 == 3'(MAX_RETRIES) ? FAULT : RESET_PLL;
        end
      STABILIZE:
        if (!lk) begin
          retry_n = r1;
          nx      = r1 == 3'(MAX_RETRIES) ? FAULT : RESET_PLL;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          retry_n = '0;
          nx      = RUN;
        end
      RUN:
        if (!lk) begin
          nx     = LOST;
          loss_n = &loss ? loss : loss + 1'b1;
        end
      LOST:    nx = RESET_PLL;
      FAULT:   nx = FAULT;
      default: nx = RESET_PLL;
    endcase
  end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scenario tests for the PLL lock supervisor
module tb_pll_lock_supervisor;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  pll_lock_supervisor_if #(.CNT_W(8)) bus ();
  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES(3),
    .CNT_W(8)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );
  always #5 refclk = ~refclk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask
  task automatic do_reset(input logic lkv);
    rst = 1'b1;
    bus.pll_locked = lkv;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset(1'b0);
    checks++;
    if ({bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.state, bus.retry_count, bus.lock_loss_count} !== {4'b1100, 3'd0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.state, bus.retry_count, bus.lock_loss_count}, {4'b1100, 3'd0, 3'd0, 8'd0});
    end
  endtask
  task automatic test_nominal;
    do_reset(1'b0);
    tick(3);
    checks++; if ({bus.pll_rst, bus.state} !== {1'b1, 3'd0}) begin errors++; $display("FAIL nom_rst_hold: got %b want 1000", {bus.pll_rst, bus.state}); end
    tick(1);
    checks++; if ({bus.pll_rst, bus.state} !== {1'b0, 3'd1}) begin errors++; $display("FAIL nom_wait: got %b want 0001", {bus.pll_rst, bus.state}); end
    tick(6);
    bus.pll_locked = 1'b1;
    tick(2);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL nom_sync_lag: got %0d want 1", bus.state); end
    tick(1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL nom_stabilize: got %0d want 2", bus.state); end
    tick(7);
    checks++; if ({bus.state, bus.sys_rst, bus.ready} !== {3'd2, 2'b10}) begin errors++; $display("FAIL nom_stab_end: got %b want 01010", {bus.state, bus.sys_rst, bus.ready}); end
    tick(1);
    checks++; if ({bus.state, bus.sys_rst, bus.ready, bus.retry_count} !== {3'd3, 2'b01, 3'd0}) begin errors++; $display("FAIL nom_run: got %b want 01101000", {bus.state, bus.sys_rst, bus.ready, bus.retry_count}); end
  endtask
  task automatic test_timeout;
    do_reset(1'b0);
    tick(23);
    checks++; if ({bus.state, bus.retry_count} !== {3'd1, 3'd0}) begin errors++; $display("FAIL to_before: got %b want 001000", {bus.state, bus.retry_count}); end
    tick(1);
    checks++; if ({bus.state, bus.retry_count, bus.pll_rst} !== {3'd0, 3'd1, 1'b1}) begin errors++; $display("FAIL to_retry: got %b want 0000011", {bus.state, bus.retry_count, bus.pll_rst}); end
    bus.pll_locked = 1'b1;
    tick(3);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd0, 1'b1}) begin errors++; $display("FAIL to_rst_hold: got %b want 0001", {bus.state, bus.pll_rst}); end
    tick(1);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin errors++; $display("FAIL to_wait2: got %b want 0010", {bus.state, bus.pll_rst}); end
    tick(8);
    checks++; if ({bus.state, bus.retry_count} !== {3'd2, 3'd1}) begin errors++; $display("FAIL to_stab2: got %b want 010001", {bus.state, bus.retry_count}); end
    tick(1);
    checks++; if ({bus.state, bus.retry_count} !== {3'd3, 3'd0}) begin errors++; $display("FAIL to_run_clear: got %b want 011000", {bus.state, bus.retry_count}); end
  endtask
  task automatic test_lock_race;
    do_reset(1'b0);
    tick(21);
    bus.pll_locked = 1'b1;
    tick(2);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL race_wait: got %0d want 1", bus.state); end
    tick(1);
    checks++; if ({bus.state, bus.retry_count} !== {3'd2, 3'd0}) begin errors++; $display("FAIL race_lock_wins: got %b want 010000", {bus.state, bus.retry_count}); end
  endtask
  task automatic test_glitch;
    logic bad;
    bad = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (bus.sys_rst !== 1'b1) bad = 1'b1;
    end
    bus.pll_locked = 1'b0;
    tick(1);
    if (bus.sys_rst !== 1'b1) bad = 1'b1;
    bus.pll_locked = 1'b1;
    tick(1);
    if (bus.sys_rst !== 1'b1) bad = 1'b1;
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL gl_stab: got %0d want 2", bus.state); end
    tick(1);
    if (bus.sys_rst !== 1'b1) bad = 1'b1;
    checks++; if ({bus.state, bus.retry_count} !== {3'd0, 3'd1}) begin errors++; $display("FAIL gl_retry: got %b want 000001", {bus.state, bus.retry_count}); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL gl_sys_rst_held: got dropped=%b want 0", bad); end
    tick(10);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL gl_final_stab: got %0d want 2", bus.state); end
    tick(1);
    checks++; if ({bus.state, bus.retry_count, bus.sys_rst} !== {3'd0, 3'd2, 1'b1}) begin errors++; $display("FAIL gl_final_fail: got %b want 0000101", {bus.state, bus.retry_count, bus.sys_rst}); end
  endtask
  task automatic test_fault;
    do_reset(1'b0);
    tick(71);
    checks++; if ({bus.state, bus.retry_count} !== {3'd1, 3'd2}) begin errors++; $display("FAIL flt_pre: got %b want 001010", {bus.state, bus.retry_count}); end
    tick(1);
    checks++; if ({bus.state, bus.fault, bus.pll_rst, bus.sys_rst, bus.ready, bus.retry_count} !== {3'd5, 4'b1110, 3'd3}) begin errors++; $display("FAIL flt_enter: got %b want 1011110011", {bus.state, bus.fault, bus.pll_rst, bus.sys_rst, bus.ready, bus.retry_count}); end
    bus.pll_locked = 1'b1;
    tick(30);
    checks++; if ({bus.state, bus.fault, bus.ready} !== {3'd5, 2'b10}) begin errors++; $display("FAIL flt_sticky: got %b want 10110", {bus.state, bus.fault, bus.ready}); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.state, bus.retry_count, bus.lock_loss_count} !== {4'b1100, 3'd0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL flt_clear: got %h want %h", {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.state, bus.retry_count, bus.lock_loss_count}, {4'b1100, 3'd0, 3'd0, 8'd0});
    end
  endtask
  task automatic test_loss_run;
    logic bad;
    bad = 1'b0;
    do_reset(1'b1);
    tick(13);
    checks++; if ({bus.state, bus.lock_loss_count} !== {3'd3, 8'd0}) begin errors++; $display("FAIL loss_run0: got %h want 300", {bus.state, bus.lock_loss_count}); end
    bus.pll_locked = 1'b0;
    tick(2);
    checks++; if ({bus.state, bus.ready} !== {3'd3, 1'b1}) begin errors++; $display("FAIL loss_lag: got %b want 0111", {bus.state, bus.ready}); end
    tick(1);
    checks++; if ({bus.state, bus.sys_rst, bus.ready, bus.pll_rst, bus.lock_loss_count} !== {3'd4, 3'b101, 8'd1}) begin errors++; $display("FAIL loss_lost: got %b want 10010100000001", {bus.state, bus.sys_rst, bus.ready, bus.pll_rst, bus.lock_loss_count}); end
    bus.pll_locked = 1'b1;
    tick(1);
    checks++; if ({bus.state, bus.retry_count} !== {3'd0, 3'd0}) begin errors++; $display("FAIL loss_reset_pll: got %b want 000000", {bus.state, bus.retry_count}); end
    tick(13);
    checks++; if ({bus.state, bus.lock_loss_count} !== {3'd3, 8'd1}) begin errors++; $display("FAIL loss_relock: got %h want 301", {bus.state, bus.lock_loss_count}); end
    for (int i = 0; i < 299; i++) begin
      bus.pll_locked = 1'b0;
      tick(3);
      bus.pll_locked = 1'b1;
      tick(14);
      if (i == 253 && bus.lock_loss_count !== 8'd255) bad = 1'b1;
      if (bus.state !== 3'd3) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL loss_loop: got bad=%b want 0", bad); end
    checks++; if ({bus.state, bus.lock_loss_count} !== {3'd3, 8'd255}) begin errors++; $display("FAIL loss_saturate: got %h want 3ff", {bus.state, bus.lock_loss_count}); end
  endtask
  task automatic test_reset_in_run;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rir_pre: got ready=%b want 1", bus.ready); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.state, bus.retry_count, bus.lock_loss_count} !== {4'b1100, 3'd0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL rir_clear: got %h want %h", {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.state, bus.retry_count, bus.lock_loss_count}, {4'b1100, 3'd0, 3'd0, 8'd0});
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    bus.pll_locked = 1'b0;
    test_reset;
    test_nominal;
    test_timeout;
    test_lock_race;
    test_glitch;
    test_fault;
    test_loss_run;
    test_reset_in_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
